// File: rtl/eth_f_pkt_client_pkg.sv
// ----------------------------------------------------------------------------
// eth_f_pkt_client_pkg
//
// Shared types for the 100G packet client loopback test logic.
//   test_ctrl_state_t : run sequencer states (IDLE, CLEAR, RUN, DRAIN, DONE)
//   fail_code_t       : result cause code reported with o_done
//   is_busy_state()   : true while a run is in progress
// ----------------------------------------------------------------------------
package eth_f_pkt_client_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } test_ctrl_state_t;

  typedef enum logic [1:0] {
    FAIL_NONE    = 2'd0,
    FAIL_DATA    = 2'd1,
    FAIL_TIMEOUT = 2'd2,
    FAIL_ABORT   = 2'd3
  } fail_code_t;

  // A run is in progress from the stat clear until the drain finishes.
  function automatic logic is_busy_state(input test_ctrl_state_t st);
    return (st == CLEAR) || (st == RUN) || (st == DRAIN);
  endfunction

endpackage

// File: rtl/eth_f_packet_client_test_ctrl.sv
// ----------------------------------------------------------------------------
// eth_f_packet_client_test_ctrl
//
// Run sequencer for the packet client loopback path. A CSR start clears the
// stat counters, enables the generator/checker, waits for the TX count to
// reach the target (one-shot) or for a stop (continuous), then drains until
// the RX count catches up. The result is reported as pass/fail plus a cause.
//
// Ports
//   i_clk, i_reset            : clock, synchronous active-high reset
//   i_start/i_stop/i_abort    : single-cycle CSR commands
//   i_cfg_pkt_num             : packets per one-shot run
//   i_cfg_cont_mode           : 1 = continuous, 0 = one-shot
//   i_cfg_timeout             : drain idle-cycle limit, 0 = no limit
//   i_tx_pkt_cnt/i_rx_pkt_cnt : free-running EOP counts from gen/checker
//   i_data_error              : sticky mismatch flag from the checker
//   o_cfg_pkt_gen_tx_en       : generator/checker enable
//   o_cfg_pkt_gen_cont_mode   : mode latched at start
//   o_dyn_pkt_num_sync        : packet target latched at start
//   o_stat_cnt_clr            : stat counter clear, high during CLEAR
//   o_busy/o_done             : run in progress / result valid
//   o_pass/o_fail_code        : result, valid while o_done
// ----------------------------------------------------------------------------
module eth_f_packet_client_test_ctrl
  import eth_f_pkt_client_pkg::*;
#(
  parameter int CLR_CYCLES = 4,
  parameter int CNT_W      = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_abort,
  input  logic [CNT_W-1:0] i_cfg_pkt_num,
  input  logic             i_cfg_cont_mode,
  input  logic [CNT_W-1:0] i_cfg_timeout,
  input  logic [CNT_W-1:0] i_tx_pkt_cnt,
  input  logic [CNT_W-1:0] i_rx_pkt_cnt,
  input  logic             i_data_error,
  output logic             o_cfg_pkt_gen_tx_en,
  output logic             o_cfg_pkt_gen_cont_mode,
  output logic [CNT_W-1:0] o_dyn_pkt_num_sync,
  output logic             o_stat_cnt_clr,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [1:0]       o_fail_code
);

  localparam int                CLR_W    = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [CLR_W-1:0]  CLR_LAST = CLR_W'(CLR_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  test_ctrl_state_t state_q, state_d;
  logic [CLR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [CNT_W-1:0] pkt_num_q, pkt_num_d;
  logic             cont_mode_q, cont_mode_d;
  logic [CNT_W-1:0] timeout_q, timeout_d;
  logic [CNT_W-1:0] tx_base_q, tx_base_d;
  logic [CNT_W-1:0] rx_base_q, rx_base_d;
  logic             err_base_q, err_base_d;
  logic [CNT_W-1:0] tx_final_q, tx_final_d;
  logic [CNT_W-1:0] rx_prev_q, rx_prev_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic             err_seen_q, err_seen_d;
  logic             tx_en_q, tx_en_d;
  logic             pass_q, pass_d;
  fail_code_t       fail_code_q, fail_code_d;

  logic [CNT_W-1:0] tx_delta;
  logic [CNT_W-1:0] rx_delta;
  logic [CNT_W-1:0] drain_tgt;
  logic [CNT_W-1:0] idle_next;
  logic             new_err;
  logic             err_now;

  // Delta arithmetic and idle tracking. Deltas are plain modulo-2^CNT_W
  // differences so free-running counters that wrap during a run still give
  // the right packet count. The idle counter measures cycles since the RX
  // count last moved; the cycle in which it moves counts as zero.
  always_comb begin
    tx_delta  = i_tx_pkt_cnt - tx_base_q;
    rx_delta  = i_rx_pkt_cnt - rx_base_q;
    drain_tgt = cont_mode_q ? tx_final_q : pkt_num_q;
    new_err   = i_data_error & ~err_base_q;
    err_now   = err_seen_q | new_err;
    if (i_rx_pkt_cnt != rx_prev_q) begin
      idle_next = '0;
    end else if (idle_cnt_q == CNT_MAX) begin
      idle_next = idle_cnt_q;
    end else begin
      idle_next = idle_cnt_q + 1'b1;
    end
  end

  // Next-state and result logic. Abort is tested first in every active state
  // so it beats stop, count match and timeout in the same cycle. A data error
  // seen anywhere in RUN/DRAIN is remembered and turns the final result into
  // a data failure, which outranks a timeout but not an abort.
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    pkt_num_d   = pkt_num_q;
    cont_mode_d = cont_mode_q;
    timeout_d   = timeout_q;
    tx_base_d   = tx_base_q;
    rx_base_d   = rx_base_q;
    err_base_d  = err_base_q;
    tx_final_d  = tx_final_q;
    rx_prev_d   = i_rx_pkt_cnt;
    idle_cnt_d  = idle_next;
    err_seen_d  = err_seen_q;
    tx_en_d     = tx_en_q;
    pass_d      = pass_q;
    fail_code_d = fail_code_q;

    case (state_q)
      IDLE, DONE: begin
        if (i_start) begin
          pkt_num_d   = i_cfg_pkt_num;
          cont_mode_d = i_cfg_cont_mode;
          timeout_d   = i_cfg_timeout;
          pass_d      = 1'b0;
          fail_code_d = FAIL_NONE;
          clr_cnt_d   = '0;
          tx_en_d     = 1'b0;
          err_seen_d  = 1'b0;
          state_d     = CLEAR;
        end
      end

      CLEAR: begin
        tx_en_d = 1'b0;
        if (i_abort) begin
          pass_d      = 1'b0;
          fail_code_d = FAIL_ABORT;
          state_d     = DONE;
        end else if (clr_cnt_q == CLR_LAST) begin
          // Baselines are taken while the clear is still asserted so the
          // deltas count only packets belonging to this run.
          tx_base_d  = i_tx_pkt_cnt;
          rx_base_d  = i_rx_pkt_cnt;
          err_base_d = i_data_error;
          err_seen_d = 1'b0;
          tx_en_d    = 1'b1;
          state_d    = RUN;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end

      RUN: begin
        err_seen_d = err_now;
        if (i_abort) begin
          tx_en_d     = 1'b0;
          pass_d      = 1'b0;
          fail_code_d = FAIL_ABORT;
          state_d     = DONE;
        end else if (!cont_mode_q) begin
          if (tx_delta == pkt_num_q) begin
            state_d = DRAIN;
          end
        end else if (i_stop) begin
          tx_final_d = tx_delta;
          state_d    = DRAIN;
        end
      end

      DRAIN: begin
        err_seen_d = err_now;
        if (i_abort) begin
          tx_en_d     = 1'b0;
          pass_d      = 1'b0;
          fail_code_d = FAIL_ABORT;
          state_d     = DONE;
        end else if (rx_delta == drain_tgt) begin
          pass_d      = ~err_now;
          fail_code_d = err_now ? FAIL_DATA : FAIL_NONE;
          state_d     = DONE;
        end else if ((timeout_q != '0) && (idle_next == timeout_q)) begin
          pass_d      = 1'b0;
          fail_code_d = err_now ? FAIL_DATA : FAIL_TIMEOUT;
          state_d     = DONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset to an all-zero,
  // idle condition.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= IDLE;
      clr_cnt_q   <= '0;
      pkt_num_q   <= '0;
      cont_mode_q <= 1'b0;
      timeout_q   <= '0;
      tx_base_q   <= '0;
      rx_base_q   <= '0;
      err_base_q  <= 1'b0;
      tx_final_q  <= '0;
      rx_prev_q   <= '0;
      idle_cnt_q  <= '0;
      err_seen_q  <= 1'b0;
      tx_en_q     <= 1'b0;
      pass_q      <= 1'b0;
      fail_code_q <= FAIL_NONE;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      pkt_num_q   <= pkt_num_d;
      cont_mode_q <= cont_mode_d;
      timeout_q   <= timeout_d;
      tx_base_q   <= tx_base_d;
      rx_base_q   <= rx_base_d;
      err_base_q  <= err_base_d;
      tx_final_q  <= tx_final_d;
      rx_prev_q   <= rx_prev_d;
      idle_cnt_q  <= idle_cnt_d;
      err_seen_q  <= err_seen_d;
      tx_en_q     <= tx_en_d;
      pass_q      <= pass_d;
      fail_code_q <= fail_code_d;
    end
  end

  // Outputs come straight from registers or from the registered state.
  assign o_cfg_pkt_gen_tx_en     = tx_en_q;
  assign o_cfg_pkt_gen_cont_mode = cont_mode_q;
  assign o_dyn_pkt_num_sync      = pkt_num_q;
  assign o_stat_cnt_clr          = (state_q == CLEAR);
  assign o_busy                  = is_busy_state(state_q);
  assign o_done                  = (state_q == DONE);
  assign o_pass                  = pass_q;
  assign o_fail_code             = fail_code_q;

endmodule

// File: tb/tb_eth_f_packet_client_test_ctrl.sv
// ----------------------------------------------------------------------------
// tb_eth_f_packet_client_test_ctrl
//
// Directed bench for the loopback run sequencer. The generator and checker
// are represented by plain TX/RX count variables driven from the bench.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, i.e. after the registers have settled.
// ----------------------------------------------------------------------------
module tb_eth_f_packet_client_test_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] pkt_num = '0;
  logic        cont = 1'b0;
  logic [31:0] timeout = '0;
  logic [31:0] tx_cnt = '0;
  logic [31:0] rx_cnt = '0;
  logic        data_err = 1'b0;

  logic        tx_en;
  logic        cont_out;
  logic [31:0] pkt_num_sync;
  logic        stat_clr;
  logic        busy;
  logic        done;
  logic        pass;
  logic [1:0]  fail_code;

  int vectors_applied = 0;
  int miscompares = 0;

  eth_f_packet_client_test_ctrl #(
    .CLR_CYCLES(4),
    .CNT_W(32)
  ) dut (
    .i_clk                  (clk),
    .i_reset                (rst),
    .i_start                (start),
    .i_stop                 (stop),
    .i_abort                (abort),
    .i_cfg_pkt_num          (pkt_num),
    .i_cfg_cont_mode        (cont),
    .i_cfg_timeout          (timeout),
    .i_tx_pkt_cnt           (tx_cnt),
    .i_rx_pkt_cnt           (rx_cnt),
    .i_data_error           (data_err),
    .o_cfg_pkt_gen_tx_en    (tx_en),
    .o_cfg_pkt_gen_cont_mode(cont_out),
    .o_dyn_pkt_num_sync     (pkt_num_sync),
    .o_stat_cnt_clr         (stat_clr),
    .o_busy                 (busy),
    .o_done                 (done),
    .o_pass                 (pass),
    .o_fail_code            (fail_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        stop;
    logic        abort;
    logic [31:0] pkt_num;
    logic        cont;
    logic [31:0] timeout;
    logic [31:0] tx;
    logic [31:0] rx;
    logic        err;
    logic        e_tx_en;
    logic        e_clr;
    logic        e_busy;
    logic        e_done;
    logic        e_pass;
    logic [1:0]  e_code;
  } vec_t;

  vec_t vecs [12];

  function automatic vec_t mkVec(input logic s, input logic sp, input logic ab,
                                 input logic [31:0] n, input logic [31:0] tx,
                                 input logic [31:0] rx, input logic e_tx_en,
                                 input logic e_clr, input logic e_busy,
                                 input logic e_done, input logic e_pass,
                                 input logic [1:0] e_code);
    vec_t v;
    v.start = s;   v.stop = sp;  v.abort = ab;
    v.pkt_num = n; v.cont = 1'b0; v.timeout = '0;
    v.tx = tx;     v.rx = rx;    v.err = 1'b0;
    v.e_tx_en = e_tx_en; v.e_clr = e_clr; v.e_busy = e_busy;
    v.e_done = e_done;   v.e_pass = e_pass; v.e_code = e_code;
    return v;
  endfunction

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkValue(input string name, input logic [31:0] act,
                            input logic [31:0] exp);
    vectors_applied++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic e_tx_en,
                             input logic e_clr, input logic e_busy,
                             input logic e_done, input logic e_pass,
                             input logic [1:0] e_code);
    checkValue({name, ".tx_en"}, {31'd0, tx_en},    {31'd0, e_tx_en});
    checkValue({name, ".clr"},   {31'd0, stat_clr}, {31'd0, e_clr});
    checkValue({name, ".busy"},  {31'd0, busy},     {31'd0, e_busy});
    checkValue({name, ".done"},  {31'd0, done},     {31'd0, e_done});
    checkValue({name, ".pass"},  {31'd0, pass},     {31'd0, e_pass});
    checkValue({name, ".code"},  {30'd0, fail_code}, {30'd0, e_code});
  endtask

  task automatic applyStimulus(input vec_t v);
    start    = v.start;
    stop     = v.stop;
    abort    = v.abort;
    pkt_num  = v.pkt_num;
    cont     = v.cont;
    timeout  = v.timeout;
    tx_cnt   = v.tx;
    rx_cnt   = v.rx;
    data_err = v.err;
    step();
    start = 1'b0;
    stop  = 1'b0;
    abort = 1'b0;
  endtask

  // Pulse start, then expect exactly four clear cycles with the enable low
  // and a cleared result, followed by the enable rising in RUN. The counts
  // present during the last clear cycle become the run baseline.
  task automatic launch(input string name, input logic [31:0] n,
                        input logic c, input logic [31:0] to);
    pkt_num = n;
    cont    = c;
    timeout = to;
    start   = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkOutput({name, ".clear"}, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
      if (i < 3) step();
    end
    step();
    checkOutput({name, ".run"}, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
  endtask

  initial begin
    // Reset state
    step();
    step();
    checkOutput("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    checkValue("reset.pkt_num_sync", pkt_num_sync, 32'd0);
    checkValue("reset.cont_mode", {31'd0, cont_out}, 32'd0);
    rst = 1'b0;

    // One-shot N=3 walked cycle by cycle: 4 clear cycles, RUN, target hit on
    // the third TX packet, a start in DRAIN ignored, RX catch-up to DONE, and
    // an abort in DONE ignored.
    vecs[0]  = mkVec(1, 0, 0, 3, 0, 0, 0, 1, 1, 0, 0, 2'd0);
    vecs[1]  = mkVec(0, 0, 0, 3, 0, 0, 0, 1, 1, 0, 0, 2'd0);
    vecs[2]  = mkVec(0, 0, 0, 3, 0, 0, 0, 1, 1, 0, 0, 2'd0);
    vecs[3]  = mkVec(0, 0, 0, 3, 0, 0, 0, 1, 1, 0, 0, 2'd0);
    vecs[4]  = mkVec(0, 0, 0, 3, 0, 0, 1, 0, 1, 0, 0, 2'd0);
    vecs[5]  = mkVec(0, 0, 0, 3, 1, 0, 1, 0, 1, 0, 0, 2'd0);
    vecs[6]  = mkVec(0, 0, 0, 3, 2, 1, 1, 0, 1, 0, 0, 2'd0);
    vecs[7]  = mkVec(0, 0, 0, 3, 3, 2, 1, 0, 1, 0, 0, 2'd0);
    vecs[8]  = mkVec(1, 0, 0, 9, 3, 2, 1, 0, 1, 0, 0, 2'd0);
    vecs[9]  = mkVec(0, 0, 0, 3, 3, 3, 1, 0, 0, 1, 1, 2'd0);
    vecs[10] = mkVec(0, 0, 0, 3, 3, 3, 1, 0, 0, 1, 1, 2'd0);
    vecs[11] = mkVec(0, 0, 1, 3, 3, 3, 1, 0, 0, 1, 1, 2'd0);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), vecs[i].e_tx_en, vecs[i].e_clr,
                  vecs[i].e_busy, vecs[i].e_done, vecs[i].e_pass, vecs[i].e_code);
    end
    checkValue("vec.pkt_num_sync", pkt_num_sync, 32'd3);

    // Counters preloaded near the wrap point, N=16.
    tx_cnt = 32'hFFFF_FFF8;
    rx_cnt = 32'hFFFF_FFF8;
    launch("wrap", 32'd16, 1'b0, 32'd0);
    for (int k = 1; k <= 16; k++) begin
      tx_cnt = tx_cnt + 1;
      rx_cnt = rx_cnt + 1;
      step();
      checkOutput($sformatf("wrap.pkt%0d", k), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    end
    step();
    checkOutput("wrap.done", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0);

    // N=8, RX loses the 8th packet, timeout 100. The idle condition is met
    // 100 cycles after the cycle carrying the 7th RX count and DONE shows on
    // the following cycle, i.e. after step 101 counted from that cycle.
    tx_cnt = '0;
    rx_cnt = '0;
    launch("tmo", 32'd8, 1'b0, 32'd100);
    for (int k = 1; k <= 8; k++) begin
      tx_cnt = k;
      if (k <= 7) rx_cnt = k;
      step();
    end
    for (int s = 3; s <= 100; s++) step();
    checkOutput("tmo.before", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    step();
    checkOutput("tmo.fire", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2);

    // Continuous mode: the configured N is ignored, stop after 37 TX packets.
    tx_cnt = '0;
    rx_cnt = '0;
    launch("cont", 32'd5, 1'b1, 32'd0);
    checkValue("cont.mode_out", {31'd0, cont_out}, 32'd1);
    for (int k = 1; k <= 37; k++) begin
      tx_cnt = k;
      if (k <= 30) rx_cnt = k;
      step();
      if (k == 5 || k == 37)
        checkOutput($sformatf("cont.tx%0d", k), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    checkOutput("cont.stop", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    for (int k = 31; k <= 37; k++) begin
      rx_cnt = k;
      step();
      checkOutput($sformatf("cont.rx%0d", k), 1'b1, 1'b0, (k != 37), (k == 37),
                  (k == 37), 2'd0);
    end

    // Data error at packet 5 of 10: run still completes, result is code 1.
    tx_cnt   = '0;
    rx_cnt   = '0;
    data_err = 1'b0;
    launch("err", 32'd10, 1'b0, 32'd0);
    for (int k = 1; k <= 10; k++) begin
      tx_cnt = k;
      rx_cnt = k;
      if (k == 5) data_err = 1'b1;
      step();
      if (k == 6 || k == 10)
        checkOutput($sformatf("err.pkt%0d", k), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    end
    step();
    checkOutput("err.done", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1);

    // Same run with the error flag already high at start: it is baselined
    // away and the run passes. Restarting from DONE also clears the code.
    tx_cnt = '0;
    rx_cnt = '0;
    launch("olderr", 32'd10, 1'b0, 32'd0);
    for (int k = 1; k <= 10; k++) begin
      tx_cnt = k;
      rx_cnt = k;
      step();
    end
    step();
    checkOutput("olderr.done", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0);

    // N=0: DRAIN on the first RUN cycle, then immediate pass.
    data_err = 1'b0;
    tx_cnt   = '0;
    rx_cnt   = '0;
    launch("n0", 32'd0, 1'b0, 32'd0);
    step();
    checkOutput("n0.drain", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    step();
    checkOutput("n0.done", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0);

    // Start during RUN ignored; abort together with stop wins.
    launch("abort", 32'd50, 1'b1, 32'd0);
    for (int k = 1; k <= 3; k++) begin
      tx_cnt = k;
      step();
    end
    pkt_num = 32'd77;
    cont    = 1'b0;
    start   = 1'b1;
    step();
    start = 1'b0;
    checkOutput("abort.start_ignored", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    checkValue("abort.pkt_num_sync", pkt_num_sync, 32'd50);
    checkValue("abort.cont_mode", {31'd0, cont_out}, 32'd1);
    abort = 1'b1;
    stop  = 1'b1;
    step();
    abort = 1'b0;
    stop  = 1'b0;
    checkOutput("abort.done", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3);

    // Reset while draining returns everything to zero in one cycle.
    tx_cnt = '0;
    rx_cnt = '0;
    launch("rstdrain", 32'd2, 1'b1, 32'd0);
    tx_cnt = 32'd2;
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    checkOutput("rstdrain.drain", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    rst = 1'b1;
    step();
    checkOutput("rstdrain.reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    checkValue("rstdrain.pkt_num_sync", pkt_num_sync, 32'd0);
    checkValue("rstdrain.cont_mode", {31'd0, cont_out}, 32'd0);
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule

// File: doc/eth_f_packet_client_test_ctrl.md
# eth_f_packet_client_test_ctrl

Test sequencer for the 100G packet client loopback path. It takes a CSR start command and steps the packet generator and data checker through a fixed run sequence: clear stats, transmit N packets (or run continuously until stopped), then drain until the RX count matches TX. It reports pass/fail with a cause code. It sits between the CSR block and the generator/checker pair and owns their enable, count-sync and stat-clear controls.

## Interface
- CLR_CYCLES, 4: cycles `o_stat_cnt_clr` is held high and `o_cfg_pkt_gen_tx_en` held low before a run.
- CNT_W, 32: packet-count and timeout width.
- i_clk  in  1  sole clock.
- i_reset  in  1  synchronous, active-high reset.
- i_start  in  1  single-cycle run request from CSR.
- i_stop  in  1  single-cycle stop request; meaningful in continuous mode.
- i_abort  in  1  single-cycle abort request.
- i_cfg_pkt_num  in  CNT_W  packets per one-shot run.
- i_cfg_cont_mode  in  1  1 = continuous, 0 = one-shot.
- i_cfg_timeout  in  CNT_W  drain idle-cycle limit; 0 disables the timeout.
- i_tx_pkt_cnt  in  CNT_W  free-running TX EOP count from the generator.
- i_rx_pkt_cnt  in  CNT_W  free-running RX EOP count from the checker (`o_packet_cnt`).
- i_data_error  in  1  sticky data-mismatch flag from the checker.
- o_cfg_pkt_gen_tx_en  out  1  generator/checker enable.
- o_cfg_pkt_gen_cont_mode  out  1  registered copy of mode, latched at start.
- o_dyn_pkt_num_sync  out  CNT_W  packet target latched at start.
- o_stat_cnt_clr  out  1  clear pulse to the stat counters.
- o_busy  out  1  high in CLEAR, RUN or DRAIN.
- o_done  out  1  high in DONE.
- o_pass  out  1  valid when `o_done`; 1 = pass.
- o_fail_code  out  2  0 = none, 1 = data error, 2 = timeout, 3 = aborted.

## Operation
- States: IDLE, CLEAR, RUN, DRAIN, DONE.
- Reset: state IDLE; all outputs 0; `o_dyn_pkt_num_sync` = 0.
- IDLE/DONE + `i_start`:
  - Latch `i_cfg_pkt_num`, `i_cfg_cont_mode` and `i_cfg_timeout`.
  - Clear `o_fail_code` and `o_pass`.
  - Go to CLEAR.
  - `i_start` in any other state is ignored.
- CLEAR:
  - `o_stat_cnt_clr` = 1 and `tx_en` = 0 for exactly CLR_CYCLES cycles.
  - On the last cycle, snapshot `tx_base` = `i_tx_pkt_cnt`, `rx_base` = `i_rx_pkt_cnt` and `err_base` = `i_data_error`.
  - Then go to RUN.
- RUN: `tx_en` = 1. Both deltas are computed modulo 2^CNT_W (subtraction wraps; no overflow flag):
  - `tx_d` = `i_tx_pkt_cnt` − `tx_base`
  - `rx_d` = `i_rx_pkt_cnt` − `rx_base`
  - One-shot: go to DRAIN when `tx_d` == latched N. N = 0 goes to DRAIN on the first RUN cycle.
  - Continuous: go to DRAIN on `i_stop`, capturing `tx_final` = `tx_d` that cycle.
- DRAIN:
  - `tx_en` stays 1 so the checker keeps its byte/tick counters.
  - `tgt` = N (one-shot) or `tx_final` (continuous).
  - `idle_cnt` resets to 0 whenever `rx_d` changes, otherwise increments, saturating.
  - Exit to DONE with pass when `rx_d` == `tgt`.
  - Exit to DONE with code 2 when timeout ≠ 0 and `idle_cnt` == timeout.
- Data error: `new_err` = `i_data_error` & ~`err_base`, sampled in RUN and DRAIN. It does not shorten the run. At DONE entry, if `new_err` has been seen, `o_fail_code` = 1 and `o_pass` = 0. Code 1 overrides code 2.
- `i_abort` in CLEAR, RUN or DRAIN: go to DONE next cycle with code 3 and `tx_en` = 0. Abort has priority over every other transition in the same cycle. Abort in IDLE/DONE is ignored.
- DONE: `tx_en` holds its last value (1 after a normal finish) so counters remain readable. It drops only through CLEAR on the next start, through abort, or through reset.
- Simultaneous events:
  - `i_stop` in one-shot mode is ignored.
  - If `i_stop` and the one-shot target are both reached in one cycle, the target wins.
- Reset mid-run returns to IDLE in one cycle with all outputs 0.

## Timing
- All outputs are registered and change on the cycle after the causing input or state change.
- Start to first `o_stat_cnt_clr`: 1 cycle. `tx_en` rises CLR_CYCLES+1 cycles after `i_start`.
- Count compare to DONE: 1 cycle. `o_done`/`o_pass`/`o_fail_code` are valid together.
- Timeout fires exactly `i_cfg_timeout` cycles after the last RX count change.

## Structure
- Shared package `eth_f_pkt_client_pkg` holds:
  - the state enum `test_ctrl_state_t`
  - `fail_code_t` constants `FAIL_NONE`, `FAIL_DATA`, `FAIL_TIMEOUT`, `FAIL_ABORT`
- No sub-modules. The delta arithmetic and idle counter stay inline.

## Test plan
- One-shot, N = 16, error-free loopback: CLR high 4 cycles, then `tx_en`; once both deltas reach 16 → DONE, `o_pass` = 1, code 0.
- Counters preloaded at 0xFFFF_FFF8 at start, N = 16: deltas wrap correctly → pass after exactly 16 packets each.
- One-shot, N = 8, RX loses 1 packet, timeout = 100: DONE with code 2 exactly 100 cycles after the 7th RX EOP.
- Continuous mode, `i_stop` after 37 TX packets: DRAIN target = 37; pass when RX delta = 37.
- Checker error asserts at packet 5 of N = 10 (`err_base` = 0): run completes, code 1, `o_pass` = 0. Repeat with error already high at start → pass.
- `i_abort` during RUN together with `i_stop`: DONE next cycle, code 3, `tx_en` = 0. `i_start` during RUN is ignored; reset during DRAIN → IDLE, all outputs 0.
